cpu_memory: RTL and testbench
=============================

CPU_MEMORY -- requirements
Module: cpu_memory

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255: maximum number of wait cycles per bus access before a fault.
REQ-002 SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_stall, input, 1 bit: downstream (writeback) stall; blocks acceptance of new ops.
REQ-005 SHALL have port i_tag, input, TAG_SIZE bits: execute-stage tag; a new op is pending when i_tag != o_tag.
REQ-006 SHALL have ports i_inst_rd (5 bits), i_rd (32 bits) and i_pc_next (32 bits), inputs: execute results; i_rd is the store data for writes.
REQ-007 SHALL have ports i_mem_read (1), i_mem_write (1), i_mem_width (3), i_mem_signed (1) and i_mem_address (32), inputs: the access request.
REQ-008 SHALL have port o_bus_request, output, 1 bit: bus transaction active.
REQ-009 SHALL have ports o_bus_rw (1, 1 = write), o_bus_address (32, word-aligned), o_bus_byte_enable (4) and o_bus_wdata (32), outputs.
REQ-010 SHALL have ports i_bus_ready (1) and i_bus_rdata (32), inputs: access complete, and read data valid with ready.
REQ-011 SHALL have ports o_tag (TAG_SIZE), o_inst_rd (5), o_rd (32) and o_pc_next (32), outputs: results forwarded to writeback.
REQ-012 SHALL have port o_fault, output, 1 bit: one-cycle pulse on a misaligned access or bus timeout.
REQ-013 SHALL have port o_stall, output, 1 bit: combinational, high while state != IDLE.

Function
REQ-014 SHALL implement states IDLE, READ and WRITE.
REQ-015 SHALL accept an op only when in IDLE, !i_stall and i_tag != o_tag.
REQ-016 SHALL complete an accepted op with neither read nor write in one cycle: o_rd <= i_rd, o_inst_rd and o_pc_next latched, o_tag <= i_tag.
REQ-017 SHALL, on an accepted read, enter READ, assert o_bus_request with o_bus_rw = 0 and o_bus_address = {addr[31:2], 2'b00}, and latch width, signed, offset, rd and pc_next.
REQ-018 SHALL, on an accepted write, enter WRITE with the following encoding:
- o_bus_rw = 1.
- Byte enables: width 1 -> 4'b0001 << addr[1:0]; width 2 -> 4'b0011 << {addr[1], 1'b0}; width 4 -> 4'b1111.
- o_bus_wdata: byte replicated x4, or halfword replicated x2.
REQ-019 SHALL sample i_bus_ready no earlier than the edge after the request is asserted, so a memory op completes in at least 2 cycles.
REQ-020 SHALL, on i_bus_ready high in READ, perform all of the following on that edge:
- Select the lane by the latched offset.
- Sign-extend when signed, otherwise zero-extend, into o_rd.
- Set o_tag <= latched tag.
- Clear o_bus_request and return to IDLE.
REQ-021 SHALL, on i_bus_ready high in WRITE, clear o_bus_request, update o_tag and return to IDLE, leaving o_rd = store data.
REQ-022 SHALL treat width 2 with addr[0] = 1, or width 4 with addr[1:0] != 0, as misaligned: no bus access, o_fault pulses for 1 cycle, the op completes in one cycle, and o_rd = 0.
REQ-023 SHALL count wait cycles in READ/WRITE; when the count reaches BUS_TIMEOUT with no ready, it SHALL drop the request, pulse o_fault, complete the op (o_rd = 0 for reads) and return to IDLE.
REQ-024 SHALL let an in-flight access complete regardless of i_stall.
REQ-025 SHALL hold o_bus_address, o_bus_rw, o_bus_byte_enable and o_bus_wdata stable while o_bus_request is high.
REQ-026 SHALL treat width values other than 1, 2 and 4 as 4.

Reset
REQ-027 SHALL, on i_reset low, immediately and asynchronously:
- Enter IDLE.
- Zero o_bus_request, o_bus_rw, o_bus_address, o_bus_byte_enable, o_bus_wdata, o_tag, o_inst_rd, o_rd, o_pc_next, o_fault and the timeout counter.
- Abort any in-flight access without completing it.

Structure
REQ-028 SHALL take TAG_SIZE from the shared CPU defines, and SHALL place the state encodings and width codes (1, 2, 4) in a shared package.
REQ-029 SHALL use one sub-module, cpu_load_align, which is combinational and performs lane selection plus sign/zero extension.

Verification
REQ-030 Bench SHALL check: lw at 0x100, ready after 3 cycles with rdata 0xDEADBEEF -> o_rd 0xDEADBEEF, o_tag updated, o_stall high for exactly 3 cycles.
REQ-031 Bench SHALL check: lb signed at 0x103, rdata 0x80FFFFFF -> o_rd 0xFFFFFF80; lbu at the same address -> o_rd 0x00000080.
REQ-032 Bench SHALL check: sh at 0x202 with data 0x1234ABCD -> o_bus_byte_enable 4'b1100, o_bus_wdata 0xABCDABCD, o_bus_address 0x200.
REQ-033 Bench SHALL check: lw at 0x101 -> o_fault one-cycle pulse, o_bus_request never asserted.
REQ-034 Bench SHALL check: lw with i_bus_ready held low and BUS_TIMEOUT = 4 -> request dropped after 4 wait cycles, o_fault pulse, o_rd = 0.
REQ-035 Bench SHALL check: reset asserted mid-READ -> o_bus_request low before the next clock edge, o_tag = 0.

Source files
------------

// File: rtl/cpu_memory_pkg.sv
// Shared definitions for the CPU memory stage: tag width, FSM states, access width
// codes and the store-side encoding helpers.
package cpu_memory_pkg;

    localparam int TAG_SIZE = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } mem_state_e;

    localparam logic [2:0] WIDTH_BYTE = 3'd1;
    localparam logic [2:0] WIDTH_HALF = 3'd2;
    localparam logic [2:0] WIDTH_WORD = 3'd4;

    // Unknown width codes fall back to a full word access.
    function automatic logic [2:0] norm_width(input logic [2:0] width);
        logic [2:0] result;
        case (width)
            WIDTH_BYTE: result = WIDTH_BYTE;
            WIDTH_HALF: result = WIDTH_HALF;
            default:    result = WIDTH_WORD;
        endcase
        return result;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] width, input logic [1:0] offset);
        logic result;
        case (width)
            WIDTH_BYTE: result = 1'b0;
            WIDTH_HALF: result = offset[0];
            default:    result = (offset != 2'd0);
        endcase
        return result;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] width, input logic [1:0] offset);
        logic [3:0] result;
        case (width)
            WIDTH_BYTE: result = 4'b0001 << offset;
            WIDTH_HALF: result = 4'b0011 << {offset[1], 1'b0};
            default:    result = 4'b1111;
        endcase
        return result;
    endfunction

    // Narrow stores are replicated across the word so every lane carries the data.
    function automatic logic [31:0] store_data(input logic [2:0] width, input logic [31:0] data);
        logic [31:0] result;
        case (width)
            WIDTH_BYTE: result = {4{data[7:0]}};
            WIDTH_HALF: result = {2{data[15:0]}};
            default:    result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/cpu_load_align.sv
// Combinational load alignment: picks the addressed byte/halfword lane out of the
// bus word and sign- or zero-extends it to 32 bits.
module cpu_load_align
    import cpu_memory_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  width,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension to a full register value.
    always_comb begin
        byte_s = rdata[{offset, 3'b000} +: 8];
        half_s = rdata[{offset[1], 4'b0000} +: 16];
        data   = 32'd0;
        case (width)
            WIDTH_BYTE: begin
                if (sign_ext) begin
                    data = {{24{byte_s[7]}}, byte_s};
                end else begin
                    data = {24'd0, byte_s};
                end
            end
            WIDTH_HALF: begin
                if (sign_ext) begin
                    data = {{16{half_s[15]}}, half_s};
                end else begin
                    data = {16'd0, half_s};
                end
            end
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/cpu_memory.sv
// CPU memory stage: accepts load/store ops from execute, drives a simple
// request/ready bus with a wait-cycle timeout, and forwards results to writeback.
module cpu_memory
    import cpu_memory_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_stall,
    input  logic [TAG_SIZE-1:0] i_tag,
    input  logic [4:0]          i_inst_rd,
    input  logic [31:0]         i_rd,
    input  logic [31:0]         i_pc_next,
    input  logic                i_mem_read,
    input  logic                i_mem_write,
    input  logic [2:0]          i_mem_width,
    input  logic                i_mem_signed,
    input  logic [31:0]         i_mem_address,
    output logic                o_bus_request,
    output logic                o_bus_rw,
    output logic [31:0]         o_bus_address,
    output logic [3:0]          o_bus_byte_enable,
    output logic [31:0]         o_bus_wdata,
    input  logic                i_bus_ready,
    input  logic [31:0]         i_bus_rdata,
    output logic [TAG_SIZE-1:0] o_tag,
    output logic [4:0]          o_inst_rd,
    output logic [31:0]         o_rd,
    output logic [31:0]         o_pc_next,
    output logic                o_fault,
    output logic                o_stall
);

    localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    mem_state_e          state_r, state_n;
    logic                bus_request_r, bus_request_n;
    logic                bus_rw_r, bus_rw_n;
    logic [31:0]         bus_address_r, bus_address_n;
    logic [3:0]          bus_byte_enable_r, bus_byte_enable_n;
    logic [31:0]         bus_wdata_r, bus_wdata_n;
    logic [TAG_SIZE-1:0] tag_r, tag_n;
    logic [4:0]          inst_rd_r, inst_rd_n;
    logic [31:0]         rd_r, rd_n;
    logic [31:0]         pc_next_r, pc_next_n;
    logic                fault_r, fault_n;
    logic [CNT_W-1:0]    wait_cnt_r, wait_cnt_n;
    logic [TAG_SIZE-1:0] pend_tag_r, pend_tag_n;
    logic [4:0]          pend_inst_rd_r, pend_inst_rd_n;
    logic [31:0]         pend_rd_r, pend_rd_n;
    logic [31:0]         pend_pc_next_r, pend_pc_next_n;
    logic [2:0]          pend_width_r, pend_width_n;
    logic                pend_signed_r, pend_signed_n;
    logic [1:0]          pend_offset_r, pend_offset_n;

    logic                accept_s;
    logic [2:0]          width_s;
    logic                misaligned_s;
    logic [31:0]         load_data_s;

    cpu_load_align u_load_align (
        .rdata    (i_bus_rdata),
        .offset   (pend_offset_r),
        .width    (pend_width_r),
        .sign_ext (pend_signed_r),
        .data     (load_data_s)
    );

    // Next-state and next-output computation for the whole stage.
    always_comb begin
        state_n           = state_r;
        bus_request_n     = bus_request_r;
        bus_rw_n          = bus_rw_r;
        bus_address_n     = bus_address_r;
        bus_byte_enable_n = bus_byte_enable_r;
        bus_wdata_n       = bus_wdata_r;
        tag_n             = tag_r;
        inst_rd_n         = inst_rd_r;
        rd_n              = rd_r;
        pc_next_n         = pc_next_r;
        fault_n           = 1'b0;
        wait_cnt_n        = wait_cnt_r;
        pend_tag_n        = pend_tag_r;
        pend_inst_rd_n    = pend_inst_rd_r;
        pend_rd_n         = pend_rd_r;
        pend_pc_next_n    = pend_pc_next_r;
        pend_width_n      = pend_width_r;
        pend_signed_n     = pend_signed_r;
        pend_offset_n     = pend_offset_r;

        width_s      = norm_width(i_mem_width);
        misaligned_s = is_misaligned(width_s, i_mem_address[1:0]);
        accept_s     = (state_r == ST_IDLE) && !i_stall && (i_tag != tag_r);

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!i_mem_read && !i_mem_write) begin
                        tag_n     = i_tag;
                        inst_rd_n = i_inst_rd;
                        rd_n      = i_rd;
                        pc_next_n = i_pc_next;
                    end else if (misaligned_s) begin
                        // Misaligned accesses never reach the bus and retire immediately.
                        tag_n     = i_tag;
                        inst_rd_n = i_inst_rd;
                        rd_n      = 32'd0;
                        pc_next_n = i_pc_next;
                        fault_n   = 1'b1;
                    end else begin
                        pend_tag_n        = i_tag;
                        pend_inst_rd_n    = i_inst_rd;
                        pend_rd_n         = i_rd;
                        pend_pc_next_n    = i_pc_next;
                        pend_width_n      = width_s;
                        pend_signed_n     = i_mem_signed;
                        pend_offset_n     = i_mem_address[1:0];
                        bus_request_n     = 1'b1;
                        bus_rw_n          = i_mem_write;
                        bus_address_n     = {i_mem_address[31:2], 2'b00};
                        bus_byte_enable_n = byte_enable(width_s, i_mem_address[1:0]);
                        bus_wdata_n       = i_mem_write ? store_data(width_s, i_rd) : 32'd0;
                        wait_cnt_n        = {CNT_W{1'b0}};
                        state_n           = i_mem_write ? ST_WRITE : ST_READ;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (i_bus_ready || (wait_cnt_r == WAIT_LAST)) begin
                    state_n       = ST_IDLE;
                    bus_request_n = 1'b0;
                    tag_n         = pend_tag_r;
                    inst_rd_n     = pend_inst_rd_r;
                    pc_next_n     = pend_pc_next_r;
                    fault_n       = !i_bus_ready;
                    if (state_r == ST_WRITE) begin
                        rd_n = pend_rd_r;
                    end else if (i_bus_ready) begin
                        rd_n = load_data_s;
                    end else begin
                        rd_n = 32'd0;
                    end
                end else begin
                    wait_cnt_n = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_n       = ST_IDLE;
                bus_request_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight access.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r           <= ST_IDLE;
            bus_request_r     <= 1'b0;
            bus_rw_r          <= 1'b0;
            bus_address_r     <= 32'd0;
            bus_byte_enable_r <= 4'd0;
            bus_wdata_r       <= 32'd0;
            tag_r             <= {TAG_SIZE{1'b0}};
            inst_rd_r         <= 5'd0;
            rd_r              <= 32'd0;
            pc_next_r         <= 32'd0;
            fault_r           <= 1'b0;
            wait_cnt_r        <= {CNT_W{1'b0}};
            pend_tag_r        <= {TAG_SIZE{1'b0}};
            pend_inst_rd_r    <= 5'd0;
            pend_rd_r         <= 32'd0;
            pend_pc_next_r    <= 32'd0;
            pend_width_r      <= WIDTH_WORD;
            pend_signed_r     <= 1'b0;
            pend_offset_r     <= 2'd0;
        end else begin
            state_r           <= state_n;
            bus_request_r     <= bus_request_n;
            bus_rw_r          <= bus_rw_n;
            bus_address_r     <= bus_address_n;
            bus_byte_enable_r <= bus_byte_enable_n;
            bus_wdata_r       <= bus_wdata_n;
            tag_r             <= tag_n;
            inst_rd_r         <= inst_rd_n;
            rd_r              <= rd_n;
            pc_next_r         <= pc_next_n;
            fault_r           <= fault_n;
            wait_cnt_r        <= wait_cnt_n;
            pend_tag_r        <= pend_tag_n;
            pend_inst_rd_r    <= pend_inst_rd_n;
            pend_rd_r         <= pend_rd_n;
            pend_pc_next_r    <= pend_pc_next_n;
            pend_width_r      <= pend_width_n;
            pend_signed_r     <= pend_signed_n;
            pend_offset_r     <= pend_offset_n;
        end
    end

    assign o_bus_request     = bus_request_r;
    assign o_bus_rw          = bus_rw_r;
    assign o_bus_address     = bus_address_r;
    assign o_bus_byte_enable = bus_byte_enable_r;
    assign o_bus_wdata       = bus_wdata_r;
    assign o_tag             = tag_r;
    assign o_inst_rd         = inst_rd_r;
    assign o_rd              = rd_r;
    assign o_pc_next         = pc_next_r;
    assign o_fault           = fault_r;
    assign o_stall           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_cpu_memory.sv
// Directed self-checking bench for cpu_memory with a short bus timeout.
module tb_cpu_memory;
    import cpu_memory_pkg::*;

    logic                i_clock = 1'b0;
    logic                i_reset;
    logic                i_stall;
    logic [TAG_SIZE-1:0] i_tag;
    logic [4:0]          i_inst_rd;
    logic [31:0]         i_rd;
    logic [31:0]         i_pc_next;
    logic                i_mem_read;
    logic                i_mem_write;
    logic [2:0]          i_mem_width;
    logic                i_mem_signed;
    logic [31:0]         i_mem_address;
    logic                o_bus_request;
    logic                o_bus_rw;
    logic [31:0]         o_bus_address;
    logic [3:0]          o_bus_byte_enable;
    logic [31:0]         o_bus_wdata;
    logic                i_bus_ready;
    logic [31:0]         i_bus_rdata;
    logic [TAG_SIZE-1:0] o_tag;
    logic [4:0]          o_inst_rd;
    logic [31:0]         o_rd;
    logic [31:0]         o_pc_next;
    logic                o_fault;
    logic                o_stall;

    int checks = 0;
    int errors = 0;
    int stall_cnt;
    int req_cnt;
    int fault_cnt;

    cpu_memory #(.BUS_TIMEOUT(4)) dut (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_stall           (i_stall),
        .i_tag             (i_tag),
        .i_inst_rd         (i_inst_rd),
        .i_rd              (i_rd),
        .i_pc_next         (i_pc_next),
        .i_mem_read        (i_mem_read),
        .i_mem_write       (i_mem_write),
        .i_mem_width       (i_mem_width),
        .i_mem_signed      (i_mem_signed),
        .i_mem_address     (i_mem_address),
        .o_bus_request     (o_bus_request),
        .o_bus_rw          (o_bus_rw),
        .o_bus_address     (o_bus_address),
        .o_bus_byte_enable (o_bus_byte_enable),
        .o_bus_wdata       (o_bus_wdata),
        .i_bus_ready       (i_bus_ready),
        .i_bus_rdata       (i_bus_rdata),
        .o_tag             (o_tag),
        .o_inst_rd         (o_inst_rd),
        .o_rd              (o_rd),
        .o_pc_next         (o_pc_next),
        .o_fault           (o_fault),
        .o_stall           (o_stall)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    task automatic issue(input logic [TAG_SIZE-1:0] tag, input logic rd_en, input logic wr_en,
                         input logic [2:0] width, input logic sgn, input logic [31:0] addr,
                         input logic [31:0] data);
        i_tag         = tag;
        i_inst_rd     = 5'(tag) + 5'd10;
        i_pc_next     = 32'h1000 + 32'(tag);
        i_rd          = data;
        i_mem_read    = rd_en;
        i_mem_write   = wr_en;
        i_mem_width   = width;
        i_mem_signed  = sgn;
        i_mem_address = addr;
    endtask

    task automatic clear_op();
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
    endtask

    initial begin
        i_reset = 1'b0; i_stall = 1'b0; i_bus_ready = 1'b0; i_bus_rdata = 32'd0;
        issue('0, 1'b0, 1'b0, 3'd4, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge i_clock);
        chk("reset_req", 32'(o_bus_request), 32'd0);
        chk("reset_tag", 32'(o_tag), 32'd0);
        chk("reset_rd", o_rd, 32'd0);
        chk("reset_stall", 32'(o_stall), 32'd0);
        chk("reset_fault", 32'(o_fault), 32'd0);
        i_reset = 1'b1;

        // lw 0x100, ready on the third wait edge
        @(negedge i_clock);
        issue(4'd1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h100, 32'd0);
        @(negedge i_clock);
        clear_op();
        chk("lw_req", 32'(o_bus_request), 32'd1);
        chk("lw_rw", 32'(o_bus_rw), 32'd0);
        chk("lw_addr", o_bus_address, 32'h100);
        stall_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_stall) stall_cnt++;
            i_bus_ready = (i == 2);
            i_bus_rdata = (i == 2) ? 32'hDEADBEEF : 32'd0;
            @(negedge i_clock);
        end
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd3);
        chk("lw_rd", o_rd, 32'hDEADBEEF);
        chk("lw_tag", 32'(o_tag), 32'd1);
        chk("lw_inst_rd", 32'(o_inst_rd), 32'd11);
        chk("lw_pc_next", o_pc_next, 32'h1001);
        chk("lw_req_done", 32'(o_bus_request), 32'd0);

        // lb signed 0x103
        issue(4'd2, 1'b1, 1'b0, 3'd1, 1'b1, 32'h103, 32'd0);
        @(negedge i_clock);
        clear_op();
        chk("lb_addr", o_bus_address, 32'h100);
        chk("lb_be", 32'(o_bus_byte_enable), 32'h8);
        i_bus_ready = 1'b1; i_bus_rdata = 32'h80FFFFFF;
        @(negedge i_clock);
        i_bus_ready = 1'b0;
        chk("lb_rd", o_rd, 32'hFFFFFF80);
        chk("lb_tag", 32'(o_tag), 32'd2);
        chk("lb_stall", 32'(o_stall), 32'd0);

        // lbu 0x103
        issue(4'd3, 1'b1, 1'b0, 3'd1, 1'b0, 32'h103, 32'd0);
        @(negedge i_clock);
        clear_op();
        i_bus_ready = 1'b1; i_bus_rdata = 32'h80FFFFFF;
        @(negedge i_clock);
        i_bus_ready = 1'b0;
        chk("lbu_rd", o_rd, 32'h00000080);
        chk("lbu_tag", 32'(o_tag), 32'd3);

        // sh 0x202, bus fields held while waiting
        issue(4'd4, 1'b0, 1'b1, 3'd2, 1'b0, 32'h202, 32'h1234ABCD);
        @(negedge i_clock);
        clear_op();
        chk("sh_rw", 32'(o_bus_rw), 32'd1);
        chk("sh_be", 32'(o_bus_byte_enable), 32'hC);
        chk("sh_wdata", o_bus_wdata, 32'hABCDABCD);
        chk("sh_addr", o_bus_address, 32'h200);
        i_rd = 32'd0; i_mem_address = 32'h0;
        @(negedge i_clock);
        chk("sh_hold_req", 32'(o_bus_request), 32'd1);
        chk("sh_hold_be", 32'(o_bus_byte_enable), 32'hC);
        chk("sh_hold_wdata", o_bus_wdata, 32'hABCDABCD);
        chk("sh_hold_addr", o_bus_address, 32'h200);
        i_bus_ready = 1'b1;
        @(negedge i_clock);
        i_bus_ready = 1'b0;
        chk("sh_rd", o_rd, 32'h1234ABCD);
        chk("sh_tag", 32'(o_tag), 32'd4);
        chk("sh_req_done", 32'(o_bus_request), 32'd0);

        // misaligned lw 0x101
        issue(4'd5, 1'b1, 1'b0, 3'd4, 1'b0, 32'h101, 32'h55);
        fault_cnt = 0; req_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clock);
            if (i == 0) clear_op();
            if (o_fault) fault_cnt++;
            if (o_bus_request) req_cnt++;
        end
        chk("mis_fault_pulses", 32'(fault_cnt), 32'd1);
        chk("mis_req_cycles", 32'(req_cnt), 32'd0);
        chk("mis_rd", o_rd, 32'd0);
        chk("mis_tag", 32'(o_tag), 32'd5);

        // plain ALU op passes straight through
        issue(4'd6, 1'b0, 1'b0, 3'd4, 1'b0, 32'h0, 32'hCAFEF00D);
        @(negedge i_clock);
        chk("alu_rd", o_rd, 32'hCAFEF00D);
        chk("alu_tag", 32'(o_tag), 32'd6);
        chk("alu_stall", 32'(o_stall), 32'd0);

        // lw timeout with ready held low
        issue(4'd7, 1'b1, 1'b0, 3'd4, 1'b0, 32'h300, 32'd0);
        fault_cnt = 0; req_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clock);
            if (i == 0) clear_op();
            if (o_fault) fault_cnt++;
            if (o_bus_request) req_cnt++;
        end
        chk("to_req_cycles", 32'(req_cnt), 32'd4);
        chk("to_fault_pulses", 32'(fault_cnt), 32'd1);
        chk("to_rd", o_rd, 32'd0);
        chk("to_tag", 32'(o_tag), 32'd7);
        chk("to_stall", 32'(o_stall), 32'd0);

        // reset during READ
        issue(4'd8, 1'b1, 1'b0, 3'd4, 1'b0, 32'h400, 32'd0);
        @(negedge i_clock);
        clear_op();
        chk("rst_pre_req", 32'(o_bus_request), 32'd1);
        #2;
        i_reset = 1'b0;
        #1;
        chk("rst_req", 32'(o_bus_request), 32'd0);
        chk("rst_tag", 32'(o_tag), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        @(negedge i_clock);
        i_tag = '0;
        i_reset = 1'b1;
        repeat (2) @(negedge i_clock);
        chk("rst_after_req", 32'(o_bus_request), 32'd0);
        chk("rst_after_rd", o_rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
